// File: rtl/motor_ramp_pkg.sv
// motor_ramp shared helpers.
// Counter width sizing used by the top and its counters.
package motor_ramp_pkg;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/motor_ramp_counter.sv
// Wrapping up-counter with a one-cycle wrap pulse.
// Ports: clk, rst (sync, high), clr, en, ovf (wrap pulse).
module motor_ramp_counter
  import motor_ramp_pkg::*;
#(
  parameter int width    = 8,
  parameter int min_val  = 0,
  parameter int max_val  = 255,
  parameter int step_val = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ovf
);

  localparam logic [width-1:0] lo  = width'(min_val);
  localparam logic [width-1:0] hi  = width'(max_val);
  localparam logic [width-1:0] inc = width'(step_val);

  logic [width-1:0] count;
  logic             wrap;

  assign wrap = (count == hi);
  assign ovf  = en && !clr && wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= lo;
    end else if (en) begin
      count <= wrap ? lo : count + inc;
    end
  end

endmodule

// File: rtl/motor_ramp.sv
// Slew-limited, dead-timed motor speed ramp feeding a pwm block.
// Ports: clk, rst (sync, high), en, cmd_valid, cmd (signed);
//        duty, dir, pwm_en, busy (all registered).
module motor_ramp
  import motor_ramp_pkg::*;
#(
  parameter int nbits       = 10,
  parameter int step        = 8,
  parameter int ramp_div    = 4800,
  parameter int dead_cycles = 4800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_valid,
  input  logic [nbits:0]   cmd,
  output logic [nbits-1:0] duty,
  output logic             dir,
  output logic             pwm_en,
  output logic             busy
);

  if (step < 1 || step > 2**nbits - 1) begin : g_bad_step
    $fatal(1, "motor_ramp: step out of range");
  end
  if (ramp_div < 1) begin : g_bad_div
    $fatal(1, "motor_ramp: ramp_div must be >= 1");
  end
  if (dead_cycles < 1) begin : g_bad_dead
    $fatal(1, "motor_ramp: dead_cycles must be >= 1");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DEAD = 2'd3;

  localparam int pw = cnt_w(ramp_div);
  localparam int dw = cnt_w(dead_cycles);

  localparam logic [nbits-1:0] full = '1;
  localparam logic [nbits-1:0] stp  = nbits'(step);

  logic [1:0]       st, st_n;
  logic [nbits-1:0] tgt, tgt_n, duty_n;
  logic [nbits-1:0] gap, mv, cmd_mag;
  logic [nbits:0]   mag;
  logic             tgt_dir, tgt_dir_n, dir_n;
  logic             in_ramp, in_dead;
  logic             tick, dead_end;
  logic             pwm_en_n, busy_n;

  assign in_ramp = en && (st == RAMP);
  assign in_dead = en && (st == DEAD);

  // Prescaler restarts whenever RAMP is (re)entered.
  motor_ramp_counter #(
    .width   (pw),
    .min_val (0),
    .max_val (ramp_div - 1),
    .step_val(1)
  ) u_pre (
    .clk(clk),
    .rst(rst),
    .clr(!in_ramp),
    .en (in_ramp),
    .ovf(tick)
  );

  motor_ramp_counter #(
    .width   (dw),
    .min_val (0),
    .max_val (dead_cycles - 1),
    .step_val(1)
  ) u_dead (
    .clk(clk),
    .rst(rst),
    .clr(!in_dead),
    .en (in_dead),
    .ovf(dead_end)
  );

  // -(-2**nbits) wraps back to 2**nbits unsigned; saturate it.
  assign mag     = cmd[nbits] ? -cmd : cmd;
  assign cmd_mag = mag[nbits] ? full : mag[nbits-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= st_n;
    end
  end

  always_comb begin
    st_n = st;
    if (!en) begin
      st_n = IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (tgt != '0) begin
            st_n = (tgt_dir != dir) ? DEAD : RAMP;
          end
        end
        RAMP: begin
          if (tgt_dir != dir) begin
            if (duty_n == '0) st_n = DEAD;
          end else if (duty_n == tgt) begin
            st_n = (tgt == '0) ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (tgt != duty || tgt_dir != dir) st_n = RAMP;
        end
        default: begin
          if (dead_end) begin
            st_n = (tgt == '0) ? IDLE : RAMP;
          end
        end
      endcase
    end
  end

  // Reversing heads for zero first; otherwise close the gap.
  always_comb begin
    duty_n    = duty;
    dir_n     = dir;
    tgt_n     = tgt;
    tgt_dir_n = tgt_dir;
    if (tgt_dir != dir) begin
      gap = duty;
    end else if (duty > tgt) begin
      gap = duty - tgt;
    end else begin
      gap = tgt - duty;
    end
    mv = (gap < stp) ? gap : stp;
    if (!en) begin
      duty_n    = '0;
      tgt_n     = '0;
      tgt_dir_n = 1'b0;
    end else begin
      if (st == RAMP && tick) begin
        if (tgt_dir == dir && tgt > duty) begin
          duty_n = duty + mv;
        end else begin
          duty_n = duty - mv;
        end
      end
      if (st == IDLE || st == DEAD) duty_n = '0;
      if (st == DEAD && dead_end) dir_n = tgt_dir;
      if (cmd_valid) begin
        tgt_n     = cmd_mag;
        tgt_dir_n = cmd[nbits];
      end
    end
  end

  assign pwm_en_n = en && (st_n != DEAD);
  assign busy_n   = (st_n == RAMP) || (st_n == DEAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      duty    <= '0;
      dir     <= 1'b0;
      pwm_en  <= 1'b0;
      busy    <= 1'b0;
      tgt     <= '0;
      tgt_dir <= 1'b0;
    end else begin
      duty    <= duty_n;
      dir     <= dir_n;
      pwm_en  <= pwm_en_n;
      busy    <= busy_n;
      tgt     <= tgt_n;
      tgt_dir <= tgt_dir_n;
    end
  end

endmodule
